// File: rtl/nas_vram_arb.sv
// rtl/nas_vram_arb.sv - NASCOM 2 video-RAM arbiter: display fetch has priority, CPU is held off with wait_n
module nas_vram_arb #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          vdusel_n,
  input  logic          rd_n,
  input  logic          wr_n,
  input  logic [15:0]   cpu_a,
  input  logic [7:0]    cpu_d,
  output logic [7:0]    cpu_rdata,
  output logic          wait_n,
  input  logic          vid_active,
  input  logic [2:0]    char_phase,
  input  logic [AW-1:0] vid_addr,
  output logic [7:0]    vid_char,
  output logic          vid_char_valid,
  output logic [AW-1:0] ram_addr,
  output logic          ram_re,
  output logic          ram_we,
  output logic [7:0]    ram_din,
  input  logic [7:0]    ram_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VID_RD,
    S_VID_CAP,
    S_CPU_ACC,
    S_CPU_CAP
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_served;
  logic          r_acc_rd;
  logic [AW-1:0] r_vid_addr;
  logic          w_cpu_req;
  logic          w_cpu_wr;
  logic          w_vid_slot;
  logic          w_vid_guard;
  logic          w_unused_a;

  assign w_cpu_req   = !vdusel_n && (!rd_n || !wr_n);
  assign w_cpu_wr    = !wr_n;
  assign w_vid_slot  = vid_active && (char_phase == 3'd7);
  // A grant at phase 5 or 6 would still be busy when the phase-0 fetch must start.
  assign w_vid_guard = vid_active && ((char_phase == 3'd5) || (char_phase == 3'd6));
  assign w_unused_a  = ^cpu_a[15:AW];

  always_comb begin
    w_next   = r_state;
    ram_addr = '0;
    ram_re   = 1'b0;
    ram_we   = 1'b0;
    ram_din  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_vid_slot) begin
          w_next = S_VID_RD;
        end else if (w_cpu_req && !r_served && !w_vid_guard) begin
          w_next = S_CPU_ACC;
        end
      end
      S_VID_RD: begin
        ram_addr = r_vid_addr;
        ram_re   = 1'b1;
        w_next   = S_VID_CAP;
      end
      S_VID_CAP: w_next = S_IDLE;
      S_CPU_ACC: begin
        ram_addr = cpu_a[AW-1:0];
        if (w_cpu_wr) begin
          ram_we  = 1'b1;
          ram_din = cpu_d;
        end else begin
          ram_re = 1'b1;
        end
        w_next = S_CPU_CAP;
      end
      S_CPU_CAP: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_served       <= 1'b0;
      r_acc_rd       <= 1'b0;
      r_vid_addr     <= '0;
      cpu_rdata      <= 8'h00;
      vid_char       <= 8'h00;
      vid_char_valid <= 1'b0;
    end else begin
      r_state        <= w_next;
      vid_char_valid <= (r_state == S_VID_CAP);
      if (char_phase == 3'd7) begin
        r_vid_addr <= vid_addr;
      end
      if (r_state == S_VID_CAP) begin
        vid_char <= ram_dout;
      end
      if (r_state == S_CPU_ACC) begin
        r_acc_rd <= !w_cpu_wr;
      end
      if ((r_state == S_CPU_CAP) && r_acc_rd) begin
        cpu_rdata <= ram_dout;
      end
      // Released strobe re-arms; one access per strobe however long it is held.
      if (!w_cpu_req) begin
        r_served <= 1'b0;
      end else if (r_state == S_CPU_CAP) begin
        r_served <= 1'b1;
      end
    end
  end

  assign wait_n = !reset_n || !(w_cpu_req && !r_served);

endmodule

// File: tb/tb_nas_vram_arb.sv
// tb/tb_nas_vram_arb.sv - randomized self-checking bench for nas_vram_arb against a slot-rule reference model
module tb_nas_vram_arb;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          vdusel_n;
  logic          rd_n;
  logic          wr_n;
  logic [15:0]   cpu_a;
  logic [7:0]    cpu_d;
  logic [7:0]    cpu_rdata;
  logic          wait_n;
  logic          vid_active;
  logic [2:0]    char_phase;
  logic [AW-1:0] vid_addr;
  logic [7:0]    vid_char;
  logic          vid_char_valid;
  logic [AW-1:0] ram_addr;
  logic          ram_re;
  logic          ram_we;
  logic [7:0]    ram_din;
  logic [7:0]    ram_dout;

  nas_vram_arb #(.AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .vdusel_n(vdusel_n), .rd_n(rd_n), .wr_n(wr_n),
    .cpu_a(cpu_a), .cpu_d(cpu_d), .cpu_rdata(cpu_rdata), .wait_n(wait_n),
    .vid_active(vid_active), .char_phase(char_phase), .vid_addr(vid_addr),
    .vid_char(vid_char), .vid_char_valid(vid_char_valid), .ram_addr(ram_addr),
    .ram_re(ram_re), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Synchronous 1Kx8 RAM macro seen by the DUT, and the bench's own expected contents.
  logic [7:0] ram     [1024];
  logic [7:0] ref_mem [1024];

  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    if (ram_re) ram_dout <= ram[ram_addr];
  end

  int n_chk = 0;
  int n_pass = 0;

  int ph = 0;
  bit vact = 1'b0;
  int vskip = 0;
  bit mon_en = 1'b0;
  bit rand_vaddr = 1'b0;
  logic [9:0] fetch_addr = '0;
  logic [7:0] exp_rdata = 8'h00;

  bit t_on = 1'b0;
  int t_k = 0;
  int t_d = 0;
  bit t_wr = 1'b0;
  logic [9:0] t_addr = '0;
  logic [7:0] t_data = '0;

  int n_we = 0;
  int n_valid = 0;
  int n_cpurd = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t phase=%0d)", tag, got, exp, $time, ph);
  endtask

  task automatic mon();
    bit acc;
    bit exp_re;
    if (vid_char_valid) n_valid++;
    if (ram_we) n_we++;
    if (vact && ram_re && ph >= 3 && ph <= 5) n_cpurd++;
    if (mon_en) begin
      acc = t_on && (t_k == t_d + 1);
      chk("ram_we", ram_we, acc && t_wr);
      if (vskip == 0) begin
        exp_re = (acc && !t_wr) || (vact && ph == 0);
        chk("ram_re", ram_re, exp_re);
        chk("vid_char_valid", vid_char_valid, vact && ph == 2);
        if (vact && ph == 0) chk("fetch_addr", ram_addr, fetch_addr);
        if (vact && ph == 2) chk("vid_char", vid_char, ref_mem[fetch_addr]);
      end
      if (acc) begin
        chk("cpu_addr", ram_addr, t_addr);
        if (t_wr) begin
          chk("cpu_din", ram_din, t_data);
          ref_mem[t_addr] = t_data;
        end else begin
          exp_rdata = ref_mem[t_addr];
        end
      end
      chk("wait_n", wait_n, !(t_on && t_k < t_d + 3));
      if (t_on && t_k == t_d + 3) chk("cpu_rdata", cpu_rdata, exp_rdata);
    end
    if (ph == 7) fetch_addr = vid_addr;
  endtask

  task automatic cyc();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    ph = (ph + 1) % 8;
    char_phase = 3'(ph);
    if (t_on) t_k++;
    if (vskip > 0) vskip--;
    if (rand_vaddr && ph == 3) vid_addr = 10'($urandom);
  endtask

  task automatic set_vact(input bit v);
    vact = v;
    vid_active = v;
    vskip = 10;
    repeat (10) cyc();
  endtask

  // Grant delay follows from the slot rules alone: with display active the CPU may
  // only be granted at phases 2-4 of a cell; otherwise it is granted at once.
  task automatic txn(input bit wr, input logic [15:0] a, input logic [7:0] d, input int hold, input int gap);
    int dl;
    int h;
    dl = 0;
    if (vact) while (!(((ph + dl) % 8) inside {2, 3, 4})) dl++;
    vdusel_n = 1'b0;
    rd_n = wr;
    wr_n = !wr;
    cpu_a = a;
    cpu_d = d;
    t_on = 1'b1;
    t_k = 0;
    t_d = dl;
    t_wr = wr;
    t_addr = a[9:0];
    t_data = d;
    h = (hold < dl + 4) ? dl + 4 : hold;
    repeat (h) cyc();
    vdusel_n = 1'b1;
    rd_n = 1'b1;
    wr_n = 1'b1;
    t_on = 1'b0;
    repeat (gap) cyc();
  endtask

  task automatic rand_txns(input int n);
    for (int i = 0; i < n; i++) begin
      txn(1'($urandom), 16'($urandom), 8'($urandom), int'($urandom_range(0, 12)), int'($urandom_range(1, 3)));
    end
  endtask

  int w0;
  int v0;
  int r0;
  logic [9:0] ra;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i] = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    ram[10'h3C0] = 8'h41;
    ref_mem[10'h3C0] = 8'h41;

    reset_n = 1'b0;
    vid_active = 1'b0;
    char_phase = 3'd0;
    vid_addr = 10'h3C0;
    vdusel_n = 1'b0;
    rd_n = 1'b1;
    wr_n = 1'b0;
    cpu_a = 16'h0805;
    cpu_d = 8'hA5;
    repeat (4) cyc();
    chk("rst_wait_n", wait_n, 1'b1);
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_ram_re", ram_re, 1'b0);
    chk("rst_ram_addr", ram_addr, 10'h000);
    chk("rst_ram_din", ram_din, 8'h00);
    chk("rst_vid_char", vid_char, 8'h00);
    chk("rst_vid_valid", vid_char_valid, 1'b0);
    chk("rst_cpu_rdata", cpu_rdata, 8'h00);

    reset_n = 1'b1;
    mon_en = 1'b1;
    txn(1'b1, 16'h0805, 8'hA5, 5, 2);
    chk("idle_write_ram", ram[10'h005], 8'hA5);
    rand_txns(10);

    vid_addr = 10'h3C0;
    set_vact(1'b1);
    v0 = n_valid;
    repeat (512) cyc();
    chk("cells_64_valid", n_valid - v0, 64);

    while (ph != 5) cyc();
    txn(1'b0, 16'h4123, 8'h00, 0, 2);

    w0 = n_we;
    txn(1'b1, 16'h0377, 8'h5C, 40, 2);
    chk("long_strobe_we", n_we - w0, 1);
    chk("long_strobe_ram", ram[10'h377], 8'h5C);

    r0 = n_cpurd;
    txn(1'b1, 16'h03FF, 8'h9E, 0, 1);
    txn(1'b0, 16'h03FF, 8'h00, 0, 1);
    txn(1'b0, 16'hFFFF, 8'h00, 0, 2);
    chk("b2b_reads", n_cpurd - r0, 2);

    rand_vaddr = 1'b1;
    rand_txns(20);
    rand_vaddr = 1'b0;
    set_vact(1'b0);
    rand_txns(5);

    // Reset landing on the write cycle must suppress the write.
    ra = 10'($urandom);
    mon_en = 1'b0;
    vdusel_n = 1'b0;
    wr_n = 1'b0;
    cpu_a = {6'd0, ra};
    cpu_d = ~ref_mem[ra];
    cyc();
    reset_n = 1'b0;
    #1;
    chk("midrst_ram_we", ram_we, 1'b0);
    chk("midrst_wait_n", wait_n, 1'b1);
    cyc();
    cyc();
    chk("midrst_ram_intact", ram[ra], ref_mem[ra]);
    vdusel_n = 1'b1;
    wr_n = 1'b1;
    reset_n = 1'b1;
    exp_rdata = 8'h00;
    chk("midrst_rdata", cpu_rdata, 8'h00);
    mon_en = 1'b1;
    set_vact(1'b1);
    rand_txns(4);
    repeat (16) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
